regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-side master for the dual-issue register file: drives we1/rd1/wdata1 and we2/rd2/wdata2.
//  Merges two in-order slot results with results from a long-latency unit (mul/FFT butterfly).
//  Long-latency results are buffered and written on free ports.
//  Keeps a pending-destination scoreboard that issue logic uses for RAW/WAW stalls.
// PARAMETERS
//  XLEN           32  datapath width
//  NREGS          32  architectural registers (addr width = $clog2(NREGS))
//  LL_FIFO_DEPTH  4   long-latency result buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1     clock; all state on rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  s1_valid     in   1     slot-1 (older) result valid this cycle
//  s1_rd        in   5     slot-1 destination
//  s1_data      in   XLEN  slot-1 result
//  s2_valid     in   1     slot-2 (younger) result valid
//  s2_rd        in   5     slot-2 destination
//  s2_data      in   XLEN  slot-2 result
//  ll_issue     in   1     long-latency op issued this cycle; marks ll_issue_rd pending
//  ll_issue_rd  in   5     destination of issued long-latency op
//  ll_valid     in   1     long-latency result offered
//  ll_ready     out  1     result accepted when ll_valid&ll_ready; = FIFO not full
//  ll_rd        in   5     long-latency result destination
//  ll_data      in   XLEN  long-latency result
//  we1,we2      out  1     register-file write enables (registered)
//  rd1,rd2      out  5     register-file write addresses (registered)
//  wdata1,2     out  XLEN  register-file write data (registered)
//  busy         out  NREGS pending mask; bit i=1 -> xi has an outstanding long-latency write
//  ll_count     out  3     FIFO occupancy, 0..LL_FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, reset_n=0): we1=we2=0, rd*=0, wdata*=0, busy=0, FIFO emptied, ll_count=0, ll_ready=1.
//   Reset mid-operation discards buffered results and pending bits immediately.
//  Candidates each cycle, in priority order:
//   C1 = s1 if s1_valid & s1_rd!=0 & !(s2_valid & s2_rd==s1_rd)
//        (WAW kill: younger slot wins, older write dropped).
//   C2 = s2 if s2_valid & s2_rd!=0.
//   C3 = FIFO head if FIFO non-empty.
//  Port 1 takes the first present candidate; port 2 takes the next one.
//   A third candidate waits; at most one FIFO pop per cycle.
//  FIFO pops only when its head is assigned a port. Slot results are never stalled.
//  Latency:
//   Slot result on cycle N -> we asserted on cycle N+1 (one register stage).
//   LL result accepted on cycle N -> earliest we on cycle N+2 (FIFO write, then pop).
//  Both ports never carry the same rd in one cycle; rd=0 never produces a write.
//  FIFO entry with rd=0: popped and discarded, consumes no port, leaves busy unchanged.
//  ll_ready=0 when full. A push and a pop in the same cycle are legal when full:
//   ready reflects pre-pop state, so a full FIFO does not accept.
//  Scoreboard:
//   Set:   busy[ll_issue_rd] <= 1 on ll_issue, if ll_issue_rd!=0.
//   Clear: on the cycle an LL result's we is asserted.
//   Set and clear of the same bit in one cycle: set wins.
//  Illegal inputs (simulation assertions, no recovery logic):
//   - slot rd equal to any busy bit;
//   - FIFO head rd equal to a same-cycle slot rd;
//   - ll_valid for an rd with busy=0.
//  The register file reads combinationally, so a value is visible to readers from the edge after we.
// STRUCTURE
//  Package rv_wb_pkg: XLEN, REG_AW, NREGS, typedef wb_req_t {logic v; logic [REG_AW-1:0] rd; logic [XLEN-1:0] d;}.
//  Sub-module wb_sync_fifo (DEPTH, wb_req_t payload, count output) holds LL results;
//   port select, WAW kill and scoreboard stay in this file.
// TESTING
//  1. reset_n low mid-traffic with FIFO=3 -> we1=we2=0, busy=0, ll_count=0 asynchronously.
//  2. s1(x5,0xA),s2(x6,0xB) -> next cycle we1=1,rd1=5,wdata1=0xA; we2=1,rd2=6,wdata2=0xB.
//  3. s1(x7,0x1),s2(x7,0x2) -> only one write next cycle: rd=7, data=0x2; s1 dropped.
//  4. ll_issue x9 (busy[9]=1); ll result 0xFF with both slots valid for 2 cycles ->
//     held in FIFO; written on the first cycle with a free port; busy[9]=0 the same cycle.
//  5. Five LL results back-to-back with both slots busy ->
//     ll_ready=0 after 4; the fifth is accepted after the first pop; order preserved.
//  6. s1 rd=0 and LL result rd=0 -> no we asserted; busy unchanged.

Source files
------------

// File: rtl/rv_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_wb_pkg
//  Purpose  : Shared widths and the write-back request record used by the
//             register-file write arbiter and its long-latency result FIFO.
//  Contents : XLEN, NREGS, REG_AW, wb_req_t {v, rd, d}
//  Revision : 1.0 - initial release
// ============================================================================
package rv_wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   d;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_sync_fifo
//  Purpose  : Small synchronous FIFO holding long-latency write-back requests
//             until the arbiter finds a free register-file port.
//  Ports    : clk, reset_n (async, active-low)
//             push/din      - enqueue (ignored when full)
//             pop/dout      - dequeue; dout is the current head (valid when !empty)
//             full, empty   - status
//             count         - occupancy 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module wb_sync_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  wb_req_t                    din,
  input  logic                       pop,
  output wb_req_t                    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Write-side master of the dual-issue register file. Merges the
//             two in-order slot results with buffered long-latency results
//             onto two registered write ports and tracks outstanding
//             long-latency destinations in a busy scoreboard.
//  Ports    : clk, reset_n (async, active-low)
//             s1_*/s2_*       - slot results (s1 older, s2 younger)
//             ll_issue/_rd    - long-latency op issued, marks rd pending
//             ll_valid/ready/rd/data - long-latency result handshake
//             we1/rd1/wdata1, we2/rd2/wdata2 - registered write ports
//             busy            - pending long-latency destinations
//             ll_count        - result FIFO occupancy
//  Notes    : XLEN and NREGS come from rv_wb_pkg.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int LL_FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               s1_valid,
  input  logic [REG_AW-1:0]                  s1_rd,
  input  logic [XLEN-1:0]                    s1_data,
  input  logic                               s2_valid,
  input  logic [REG_AW-1:0]                  s2_rd,
  input  logic [XLEN-1:0]                    s2_data,
  input  logic                               ll_issue,
  input  logic [REG_AW-1:0]                  ll_issue_rd,
  input  logic                               ll_valid,
  output logic                               ll_ready,
  input  logic [REG_AW-1:0]                  ll_rd,
  input  logic [XLEN-1:0]                    ll_data,
  output logic                               we1,
  output logic [REG_AW-1:0]                  rd1,
  output logic [XLEN-1:0]                    wdata1,
  output logic                               we2,
  output logic [REG_AW-1:0]                  rd2,
  output logic [XLEN-1:0]                    wdata2,
  output logic [NREGS-1:0]                   busy,
  output logic [$clog2(LL_FIFO_DEPTH+1)-1:0] ll_count
);

  wb_req_t          head;
  wb_req_t          push_req;
  wb_req_t          p1;
  wb_req_t          p2;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             c1;
  logic             c2;
  logic             c3;
  logic             discard;
  logic             ll_won;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // Ready is the pre-pop full flag, so a full FIFO never accepts even when
  // it pops in the same cycle.
  assign ll_ready  = ~fifo_full;
  assign fifo_push = ll_valid & ~fifo_full;
  assign push_req  = '{v: 1'b1, rd: ll_rd, d: ll_data};

  wb_sync_fifo #(
    .DEPTH (LL_FIFO_DEPTH)
  ) u_ll_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (push_req),
    .pop     (fifo_pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (ll_count)
  );

  // Candidates. The older slot is dropped when the younger slot writes the
  // same register in the same cycle (WAW kill), which also guarantees the
  // two ports never carry the same rd.
  assign c1      = s1_valid & (s1_rd != '0) & ~(s2_valid & (s2_rd == s1_rd));
  assign c2      = s2_valid & (s2_rd != '0);
  assign c3      = ~fifo_empty & head.v & (head.rd != '0);
  // An rd=0 head is dropped without consuming a port.
  assign discard = ~fifo_empty & head.v & (head.rd == '0);

  always_comb begin
    p1     = '0;
    p2     = '0;
    ll_won = 1'b0;
    if (c1) begin
      p1 = '{v: 1'b1, rd: s1_rd, d: s1_data};
      if (c2) begin
        p2 = '{v: 1'b1, rd: s2_rd, d: s2_data};
      end else if (c3) begin
        p2     = head;
        ll_won = 1'b1;
      end
    end else if (c2) begin
      p1 = '{v: 1'b1, rd: s2_rd, d: s2_data};
      if (c3) begin
        p2     = head;
        ll_won = 1'b1;
      end
    end else if (c3) begin
      p1     = head;
      ll_won = 1'b1;
    end
  end

  assign fifo_pop = ll_won | discard;

  // Scoreboard: the clear lands on the same edge that raises we for the
  // long-latency write; a same-cycle set of the same bit wins.
  assign set_mask = (ll_issue && (ll_issue_rd != '0)) ? (NREGS'(1) << ll_issue_rd) : '0;
  assign clr_mask = ll_won ? (NREGS'(1) << head.rd) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we1    <= 1'b0;
      rd1    <= '0;
      wdata1 <= '0;
      we2    <= 1'b0;
      rd2    <= '0;
      wdata2 <= '0;
    end else begin
      we1    <= p1.v;
      rd1    <= p1.rd;
      wdata1 <= p1.d;
      we2    <= p2.v;
      rd2    <= p2.rd;
      wdata2 <= p2.d;
    end
  end

  // Illegal-input checks: the issue logic is expected to stall on busy.
  a_s1_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
    (s1_valid && s1_rd != '0) |-> !busy[s1_rd]);
  a_s2_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
    (s2_valid && s2_rd != '0) |-> !busy[s2_rd]);
  a_head_vs_slot: assert property (@(posedge clk) disable iff (!reset_n)
    (!fifo_empty && head.rd != '0) |->
      !((s1_valid && s1_rd == head.rd) || (s2_valid && s2_rd == head.rd)));
  a_ll_pending: assert property (@(posedge clk) disable iff (!reset_n)
    (ll_valid && ll_rd != '0) |-> busy[ll_rd]);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s1_valid, s2_valid, ll_issue, ll_valid;
  logic [4:0]  s1_rd, s2_rd, ll_issue_rd, ll_rd;
  logic [31:0] s1_data, s2_data, ll_data;
  logic        ll_ready, we1, we2;
  logic [4:0]  rd1, rd2;
  logic [31:0] wdata1, wdata2, busy;
  logic [2:0]  ll_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.LL_FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s1_valid    (s1_valid),
    .s1_rd       (s1_rd),
    .s1_data     (s1_data),
    .s2_valid    (s2_valid),
    .s2_rd       (s2_rd),
    .s2_data     (s2_data),
    .ll_issue    (ll_issue),
    .ll_issue_rd (ll_issue_rd),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .we1         (we1),
    .rd1         (rd1),
    .wdata1      (wdata1),
    .we2         (we2),
    .rd2         (rd2),
    .wdata2      (wdata2),
    .busy        (busy),
    .ll_count    (ll_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    s1_valid = 0; s1_rd = 0; s1_data = 0;
    s2_valid = 0; s2_rd = 0; s2_data = 0;
    ll_issue = 0; ll_issue_rd = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
  endtask

  task automatic slots(input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2);
    s1_valid = 1; s1_rd = r1; s1_data = d1;
    s2_valid = 1; s2_rd = r2; s2_data = d2;
  endtask

  task automatic test_reset;
    reset_n = 0;
    clear_inputs();
    step(); step();
    checks++; if (we1 !== 0 || we2 !== 0) begin errors++; $display("FAIL reset_we got we1=%b we2=%b exp 0 0", we1, we2); end
    checks++; if (rd1 !== 0 || rd2 !== 0 || wdata1 !== 0 || wdata2 !== 0) begin errors++; $display("FAIL reset_port got rd1=%0d rd2=%0d wd1=%h wd2=%h exp zeros", rd1, rd2, wdata1, wdata2); end
    checks++; if (busy !== 0 || ll_count !== 0 || ll_ready !== 1) begin errors++; $display("FAIL reset_state got busy=%h cnt=%0d rdy=%b exp 0 0 1", busy, ll_count, ll_ready); end
    reset_n = 1;
    step();
  endtask

  task automatic test_two_slots;
    slots(5, 32'hA, 6, 32'hB);
    step();
    checks++; if (we1 !== 1 || rd1 !== 5 || wdata1 !== 32'hA) begin errors++; $display("FAIL two_slots_p1 got we=%b rd=%0d d=%h exp 1 5 a", we1, rd1, wdata1); end
    checks++; if (we2 !== 1 || rd2 !== 6 || wdata2 !== 32'hB) begin errors++; $display("FAIL two_slots_p2 got we=%b rd=%0d d=%h exp 1 6 b", we2, rd2, wdata2); end
    clear_inputs();
    step();
    checks++; if (we1 !== 0 || we2 !== 0) begin errors++; $display("FAIL two_slots_idle got we1=%b we2=%b exp 0 0", we1, we2); end
  endtask

  task automatic test_waw;
    slots(7, 32'h1, 7, 32'h2);
    step();
    checks++; if (we1 !== 1 || rd1 !== 7 || wdata1 !== 32'h2) begin errors++; $display("FAIL waw_p1 got we=%b rd=%0d d=%h exp 1 7 2", we1, rd1, wdata1); end
    checks++; if (we2 !== 0) begin errors++; $display("FAIL waw_p2 got we2=%b exp 0", we2); end
    clear_inputs();
    step();
  endtask

  task automatic test_ll_hold;
    ll_issue = 1; ll_issue_rd = 9;
    step();
    ll_issue = 0; ll_issue_rd = 0;
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL ll_hold_busy_set got %h exp 00000200", busy); end
    slots(1, 32'h11, 2, 32'h22);
    ll_valid = 1; ll_rd = 9; ll_data = 32'hFF;
    step();
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    checks++; if (ll_count !== 1 || we1 !== 1 || rd1 !== 1 || we2 !== 1 || rd2 !== 2) begin errors++; $display("FAIL ll_hold_c1 got cnt=%0d rd1=%0d rd2=%0d exp 1 1 2", ll_count, rd1, rd2); end
    step();
    checks++; if (ll_count !== 1 || busy !== 32'h0000_0200 || rd2 !== 2) begin errors++; $display("FAIL ll_hold_c2 got cnt=%0d busy=%h rd2=%0d exp 1 00000200 2", ll_count, busy, rd2); end
    clear_inputs();
    step();
    checks++; if (we1 !== 1 || rd1 !== 9 || wdata1 !== 32'hFF || we2 !== 0) begin errors++; $display("FAIL ll_hold_write got we1=%b rd1=%0d d=%h we2=%b exp 1 9 ff 0", we1, rd1, wdata1, we2); end
    checks++; if (busy !== 0 || ll_count !== 0) begin errors++; $display("FAIL ll_hold_clear got busy=%h cnt=%0d exp 0 0", busy, ll_count); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 5; k++) begin
      ll_issue = 1; ll_issue_rd = 5'(10 + k);
      step();
    end
    ll_issue = 0; ll_issue_rd = 0;
    checks++; if (busy !== 32'h0000_7C00) begin errors++; $display("FAIL b2b_busy got %h exp 00007c00", busy); end
    slots(1, 32'h11, 2, 32'h22);
    for (int k = 0; k < 4; k++) begin
      ll_valid = 1; ll_rd = 5'(10 + k); ll_data = 32'h100 + k;
      checks++; if (ll_ready !== 1) begin errors++; $display("FAIL b2b_ready_%0d got %b exp 1", k, ll_ready); end
      step();
      checks++; if (ll_count !== 3'(k + 1)) begin errors++; $display("FAIL b2b_count_%0d got %0d exp %0d", k, ll_count, k + 1); end
    end
    // fifth offered while full; free port 2 so the head pops
    ll_rd = 14; ll_data = 32'h104;
    s2_valid = 0;
    checks++; if (ll_ready !== 0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", ll_ready); end
    step();
    checks++; if (we1 !== 1 || rd1 !== 1 || we2 !== 1 || rd2 !== 10 || wdata2 !== 32'h100) begin errors++; $display("FAIL b2b_pop1 got we2=%b rd2=%0d d=%h exp 1 10 100", we2, rd2, wdata2); end
    checks++; if (ll_count !== 3 || busy !== 32'h0000_7800 || ll_ready !== 1) begin errors++; $display("FAIL b2b_after_pop got cnt=%0d busy=%h rdy=%b exp 3 00007800 1", ll_count, busy, ll_ready); end
    s2_valid = 1;
    step();
    checks++; if (ll_count !== 4) begin errors++; $display("FAIL b2b_fifth_accept got %0d exp 4", ll_count); end
    clear_inputs();
    for (int k = 1; k < 5; k++) begin
      step();
      checks++; if (we1 !== 1 || rd1 !== 5'(10 + k) || wdata1 !== 32'h100 + k || we2 !== 0) begin errors++; $display("FAIL b2b_drain_%0d got we1=%b rd1=%0d d=%h we2=%b exp 1 %0d %h 0", k, we1, rd1, wdata1, we2, 10 + k, 32'h100 + k); end
      checks++; if (ll_count !== 3'(4 - k)) begin errors++; $display("FAIL b2b_drain_cnt_%0d got %0d exp %0d", k, ll_count, 4 - k); end
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL b2b_busy_end got %h exp 0", busy); end
    step();
  endtask

  task automatic test_zero_rd;
    ll_issue = 1; ll_issue_rd = 3;
    step();
    ll_issue = 0; ll_issue_rd = 0;
    s1_valid = 1; s1_rd = 0; s1_data = 32'hDEAD;
    ll_valid = 1; ll_rd = 0; ll_data = 32'h55;
    step();
    clear_inputs();
    checks++; if (we1 !== 0 || we2 !== 0 || ll_count !== 1) begin errors++; $display("FAIL zero_rd_c1 got we1=%b we2=%b cnt=%0d exp 0 0 1", we1, we2, ll_count); end
    step();
    checks++; if (we1 !== 0 || we2 !== 0 || ll_count !== 0) begin errors++; $display("FAIL zero_rd_discard got we1=%b we2=%b cnt=%0d exp 0 0 0", we1, we2, ll_count); end
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL zero_rd_busy got %h exp 00000008", busy); end
  endtask

  task automatic test_reset_midtraffic;
    for (int k = 0; k < 3; k++) begin
      ll_issue = 1; ll_issue_rd = 5'(20 + k);
      step();
    end
    ll_issue = 0; ll_issue_rd = 0;
    slots(1, 32'h33, 2, 32'h44);
    for (int k = 0; k < 3; k++) begin
      ll_valid = 1; ll_rd = 5'(20 + k); ll_data = 32'h200 + k;
      step();
    end
    ll_valid = 0; ll_rd = 0;
    checks++; if (ll_count !== 3 || we1 !== 1 || busy !== 32'h0070_0008) begin errors++; $display("FAIL mid_pre got cnt=%0d we1=%b busy=%h exp 3 1 00700008", ll_count, we1, busy); end
    #3;
    reset_n = 0;
    #1;
    checks++; if (we1 !== 0 || we2 !== 0 || busy !== 0 || ll_count !== 0 || ll_ready !== 1) begin errors++; $display("FAIL mid_reset got we1=%b we2=%b busy=%h cnt=%0d rdy=%b exp 0 0 0 0 1", we1, we2, busy, ll_count, ll_ready); end
    clear_inputs();
    step(); step();
    reset_n = 1;
    step();
    checks++; if (we1 !== 0 || ll_count !== 0) begin errors++; $display("FAIL mid_after got we1=%b cnt=%0d exp 0 0", we1, ll_count); end
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    test_reset();
    test_two_slots();
    test_waw();
    test_ll_hold();
    test_back_to_back();
    test_zero_rd();
    test_reset_midtraffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
